sin_phase_gen: RTL and testbench

Phase-accumulator address generator (NCO front end) that drives the sin_table ROM. Each cycle it produces a table address and read strobe, giving a programmable-frequency sine stream at the sin_table d_out. It supports continuous or N-period bursts, stop on demand, and glitch-free tuning-word updates. It also generates a sample_valid flag aligned to the table's one-cycle registered read.

---
 rtl/sin_phase_gen.sv | 148 ++++++++++++++
 tb/tb_sin_phase_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sin_phase_gen.sv
// Phase-accumulator address generator feeding the sin_table ROM.
// Produces a registered address/read strobe with burst, stop and double-buffered tuning control.
module sin_phase_gen #(
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PER_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              fcw_wr,
    input  logic [ACC_W-1:0]  fcw_in,
    input  logic [ADDR_W-1:0] phase_off,
    input  logic [PER_W-1:0]  num_periods,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic              sample_valid,
    output logic              wrap,
    output logic [PER_W-1:0]  period_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  fcw_shadow_q;
    logic [ACC_W-1:0]  fcw_active_q;
    logic [PER_W-1:0]  burst_len_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    logic              sample_valid_q;
    logic              wrap_q;
    logic [PER_W-1:0]  period_cnt_q;
    logic              busy_q;
    logic              done_q;

    logic [ACC_W:0]    acc_sum_c;
    logic [ACC_W-1:0]  acc_d;
    logic              carry_c;
    logic [ADDR_W-1:0] addr_d;
    logic [PER_W:0]    cnt_inc_c;
    logic [PER_W-1:0]  period_cnt_d;
    logic              burst_end_c;

    // Next accumulator, table address and saturating period count for the RUN state.
    always_comb begin
        acc_sum_c    = {1'b0, acc_q} + {1'b0, fcw_active_q};
        acc_d        = acc_sum_c[ACC_W-1:0];
        carry_c      = acc_sum_c[ACC_W];
        addr_d       = acc_d[ACC_W-1 -: ADDR_W] + phase_off;
        cnt_inc_c    = {1'b0, period_cnt_q} + (PER_W+1)'(1);
        period_cnt_d = (&period_cnt_q) ? period_cnt_q : cnt_inc_c[PER_W-1:0];
        burst_end_c  = carry_c && (burst_len_q != '0) && (cnt_inc_c == {1'b0, burst_len_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            fcw_shadow_q   <= ACC_W'(1);
            fcw_active_q   <= ACC_W'(1);
            burst_len_q    <= '0;
            addr_q         <= '0;
            rd_q           <= 1'b0;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
            period_cnt_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            sample_valid_q <= rd_q;
            done_q         <= 1'b0;
            wrap_q         <= 1'b0;
            if (fcw_wr) begin
                fcw_shadow_q <= fcw_in;
            end

            case (state_q)
                S_IDLE: begin
                    rd_q <= 1'b0;
                    if (fcw_wr) begin
                        fcw_active_q <= fcw_in;
                    end
                    if (start) begin
                        acc_q        <= '0;
                        addr_q       <= phase_off;
                        rd_q         <= 1'b1;
                        period_cnt_q <= '0;
                        burst_len_q  <= num_periods;
                        busy_q       <= 1'b1;
                        state_q      <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        // stop wins over a coincident carry: nothing advances
                        rd_q    <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        acc_q  <= acc_d;
                        wrap_q <= carry_c;
                        if (carry_c) begin
                            period_cnt_q <= period_cnt_d;
                            fcw_active_q <= fcw_shadow_q;
                        end
                        if (burst_end_c) begin
                            rd_q    <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            addr_q <= addr_d;
                            rd_q   <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    rd_q    <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    rd_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addr         = addr_q;
    assign rd           = rd_q;
    assign sample_valid = sample_valid_q;
    assign wrap         = wrap_q;
    assign period_cnt   = period_cnt_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sin_phase_gen.sv
// Directed bench for sin_phase_gen: expected outputs are queued as stimulus is driven
// and compared one cycle later against the registered outputs.
module tb_sin_phase_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        fcw_wr;
    logic [15:0] fcw_in;
    logic [7:0]  phase_off;
    logic [7:0]  num_periods;
    logic [7:0]  addr;
    logic        rd;
    logic        sample_valid;
    logic        wrap;
    logic [7:0]  period_cnt;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [7:0] addr;
        logic       rd;
        logic       sv;
        logic       wrap;
        logic [7:0] pcnt;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t  sb_q[$];
    logic  last_rd;
    int    vectors;
    int    miscompares;
    string tag;

    sin_phase_gen #(.ACC_W(16), .ADDR_W(8), .PER_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .fcw_wr       (fcw_wr),
        .fcw_in       (fcw_in),
        .phase_off    (phase_off),
        .num_periods  (num_periods),
        .addr         (addr),
        .rd           (rd),
        .sample_valid (sample_valid),
        .wrap         (wrap),
        .period_cnt   (period_cnt),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sample_valid is expected to echo the previously expected rd
    task automatic expect_out(input logic [7:0] a, input logic r, input logic w,
                              input logic [7:0] pc, input logic b, input logic d);
        obs_t e;
        e.addr = a; e.rd = r; e.sv = last_rd; e.wrap = w;
        e.pcnt = pc; e.busy = b; e.done = d;
        last_rd = r;
        sb_q.push_back(e);
    endtask

    task automatic compare_head();
        obs_t o;
        obs_t e;
        o = '{addr: addr, rd: rd, sv: sample_valid, wrap: wrap,
              pcnt: period_cnt, busy: busy, done: done};
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, o);
        end else begin
            e = sb_q.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed addr=%h rd=%b sv=%b wrap=%b pcnt=%h busy=%b done=%b expected addr=%h rd=%b sv=%b wrap=%b pcnt=%h busy=%b done=%b",
                       tag, o.addr, o.rd, o.sv, o.wrap, o.pcnt, o.busy, o.done,
                       e.addr, e.rd, e.sv, e.wrap, e.pcnt, e.busy, e.done);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic idle_cycle(input logic [7:0] a, input logic [7:0] pc);
        expect_out(a, 1'b0, 1'b0, pc, 1'b0, 1'b0);
        tick();
    endtask

    task automatic write_fcw_idle(input logic [15:0] f, input logic [7:0] a, input logic [7:0] pc);
        fcw_wr = 1'b1;
        fcw_in = f;
        expect_out(a, 1'b0, 1'b0, pc, 1'b0, 1'b0);
        tick();
        fcw_wr = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] off, input logic [7:0] np);
        start       = 1'b1;
        phase_off   = off;
        num_periods = np;
        expect_out(off, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        start = 1'b0;
    endtask

    // Closed form: after k steps the accumulator holds fcw*k (mod 2^16), periods = fcw*k / 2^16
    task automatic run_const(input int unsigned fcw, input logic [7:0] off, input int n);
        longint acc;
        longint prev;
        longint per;
        logic   w;
        for (int k = 1; k <= n; k++) begin
            acc  = longint'(fcw) * longint'(k);
            prev = acc - longint'(fcw);
            w    = (acc >> 16) != (prev >> 16);
            per  = acc >> 16;
            if (per > 255) per = 255;
            expect_out(8'((acc >> 8) + longint'(off)), 1'b1, w, 8'(per), 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic stop_drain(input logic [7:0] a, input logic [7:0] pc);
        stop = 1'b1;
        expect_out(a, 1'b0, 1'b0, pc, 1'b1, 1'b0);
        tick();
        stop = 1'b0;
        expect_out(a, 1'b0, 1'b0, pc, 1'b0, 1'b1);
        tick();
        expect_out(a, 1'b0, 1'b0, pc, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0; last_rd = 1'b0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; fcw_wr = 1'b0;
        fcw_in = '0; phase_off = '0; num_periods = '0;

        tag = "reset";
        #3;
        expect_out(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        compare_head();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle(8'h00, 8'h00);

        tag = "cont_step1";
        write_fcw_idle(16'h0100, 8'h00, 8'h00);
        start_run(8'h00, 8'h00);
        run_const(32'h0100, 8'h00, 256);
        stop_drain(8'h00, 8'h01);

        tag = "burst2";
        start_run(8'h00, 8'h02);
        run_const(32'h0100, 8'h00, 511);
        expect_out(8'hFF, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        tick();
        expect_out(8'hFF, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
        tick();
        expect_out(8'hFF, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        tick();

        tag = "half_off40";
        write_fcw_idle(16'h8000, 8'hFF, 8'h02);
        start_run(8'h40, 8'h00);
        run_const(32'h8000, 8'h40, 6);
        stop_drain(8'h40, 8'h03);

        tag = "step_half";
        write_fcw_idle(16'h0080, 8'h40, 8'h03);
        start_run(8'h00, 8'h00);
        run_const(32'h0080, 8'h00, 8);
        stop_drain(8'h04, 8'h00);

        tag = "fcw_update";
        write_fcw_idle(16'h0100, 8'h04, 8'h00);
        start_run(8'h00, 8'h00);
        fcw_in = 16'h0200;
        for (int k = 1; k <= 256; k++) begin
            fcw_wr = (k == 17);
            expect_out(8'(k), 1'b1, k == 256, (k == 256) ? 8'h01 : 8'h00, 1'b1, 1'b0);
            tick();
        end
        tag = "fcw_on_wrap";
        fcw_in = 16'h0400;
        for (int j = 1; j <= 128; j++) begin
            fcw_wr = (j == 128);
            expect_out(8'(2 * j), 1'b1, j == 128, (j == 128) ? 8'h02 : 8'h01, 1'b1, 1'b0);
            tick();
        end
        fcw_wr = 1'b0;
        for (int j = 1; j <= 128; j++) begin
            expect_out(8'(2 * j), 1'b1, j == 128, (j == 128) ? 8'h03 : 8'h02, 1'b1, 1'b0);
            tick();
        end
        for (int j = 1; j <= 4; j++) begin
            expect_out(8'(4 * j), 1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
            tick();
        end
        stop_drain(8'h10, 8'h03);

        tag = "stop_37";
        write_fcw_idle(16'h0100, 8'h10, 8'h03);
        start_run(8'h00, 8'h00);
        run_const(32'h0100, 8'h00, 8'h37);
        stop_drain(8'h37, 8'h00);

        tag = "start_stop";
        stop = 1'b1;
        start_run(8'h00, 8'h00);
        stop_drain(8'h00, 8'h00);

        tag = "rst_midrun";
        start_run(8'h00, 8'h00);
        run_const(32'h0100, 8'h00, 128);
        #2;
        rst = 1'b1;
        #1;
        last_rd = 1'b0;
        expect_out(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        compare_head();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle(8'h00, 8'h00);
        idle_cycle(8'h00, 8'h00);
        idle_cycle(8'h00, 8'h00);

        tag = "fcw_default";
        start_run(8'h00, 8'h00);
        run_const(32'h0001, 8'h00, 257);
        stop_drain(8'h01, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
